// File: rtl/scope_ui_pkg.sv
// Shared definitions for the scope user-interface blocks: arbiter states,
// draggable handle IDs, default handle values and a coordinate clamp helper.
package scope_ui_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAG     = 2'd1,
        COMMIT   = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    localparam logic [1:0] HID_TRIG_LEVEL = 2'd0;
    localparam logic [1:0] HID_TRIG_POS   = 2'd1;
    localparam logic [1:0] HID_CH1        = 2'd2;
    localparam logic [1:0] HID_CH2        = 2'd3;

    localparam int unsigned DEF_TRIG_LEVEL = 200;
    localparam int unsigned DEF_TRIG_POS   = 320;
    localparam int unsigned DEF_CH1_OFFSET = 120;
    localparam int unsigned DEF_CH2_OFFSET = 360;

    // Saturate a 12-bit cursor coordinate into a 10-bit handle range.
    function automatic logic [9:0] clamp_coord(input logic [11:0] v,
                                               input logic [9:0]  lo,
                                               input logic [9:0]  hi);
        if (v < {2'b00, lo}) begin
            return lo;
        end else if (v > {2'b00, hi}) begin
            return hi;
        end
        return v[9:0];
    endfunction

endpackage

// File: rtl/drag_hit_test.sv
// Hit test for one handle: the cursor must lie within +/-1 of a fixed marker
// line on one axis and within +/-1 of the handle's current value on the other.
module drag_hit_test #(
    parameter int unsigned MARK = 0
) (
    input  logic [11:0] mark_coord_i,
    input  logic [11:0] track_coord_i,
    input  logic [9:0]  value_i,
    output logic        hit_o
);

    logic [12:0] mark_c;
    logic [12:0] mark_p;
    logic [12:0] track_c;
    logic [12:0] track_p;
    logic        mark_hit;
    logic        track_hit;

    assign mark_c  = 13'(MARK);
    assign mark_p  = {1'b0, mark_coord_i};
    assign track_c = {3'b000, value_i};
    assign track_p = {1'b0, track_coord_i};

    // Window is p+1 >= c && p <= c+1, so a centre of 0 yields [0,1] with no wrap.
    assign mark_hit  = (mark_p + 13'd1 >= mark_c) && (mark_p <= mark_c + 13'd1);
    assign track_hit = (track_p + 13'd1 >= track_c) && (track_p <= track_c + 13'd1);
    assign hit_o     = mark_hit && track_hit;

endmodule

// File: rtl/mouse_drag_arbiter.sv
// Left-button drag arbiter for the four scope handles: grants one owner on
// press, tracks the cursor with clamping, commits on release, cancels on right-click.
module mouse_drag_arbiter
    import scope_ui_pkg::*;
#(
    parameter int unsigned TRIG_MARK_X    = 557,
    parameter int unsigned TPOS_MARK_Y    = 8,
    parameter int unsigned CH1_MARK_X     = 2,
    parameter int unsigned CH2_MARK_X     = 6,
    parameter int unsigned Y_MIN          = 0,
    parameter int unsigned Y_MAX          = 479,
    parameter int unsigned X_MIN          = 0,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned TRIG_LEVEL_RST = DEF_TRIG_LEVEL,
    parameter int unsigned TRIG_POS_RST   = DEF_TRIG_POS,
    parameter int unsigned CH1_RST        = DEF_CH1_OFFSET,
    parameter int unsigned CH2_RST        = DEF_CH2_OFFSET
) (
    input  logic        CLK_50MHZ,
    input  logic        MASTER_RST,
    input  logic [11:0] XCOORD,
    input  logic [11:0] YCOORD,
    input  logic        L_BUTTON,
    input  logic        R_BUTTON,
    output logic [8:0]  TRIG_LEVEL,
    output logic [9:0]  TRIG_POS,
    output logic [8:0]  CH1_OFFSET,
    output logic [8:0]  CH2_OFFSET,
    output logic        DRAG_ACTIVE,
    output logic [1:0]  DRAG_OWNER,
    output logic        COMMIT_REQ,
    output logic [1:0]  COMMIT_ID,
    input  logic        COMMIT_ACK
);

    localparam logic [9:0] Y_LO = 10'(Y_MIN);
    localparam logic [9:0] Y_HI = 10'(Y_MAX);
    localparam logic [9:0] X_LO = 10'(X_MIN);
    localparam logic [9:0] X_HI = 10'(X_MAX);

    state_e      state_q, state_d;
    logic        l_buf_q;
    logic [8:0]  trig_level_q, trig_level_d;
    logic [9:0]  trig_pos_q, trig_pos_d;
    logic [8:0]  ch1_q, ch1_d;
    logic [8:0]  ch2_q, ch2_d;
    logic [1:0]  owner_q, owner_d;
    logic [9:0]  saved_q, saved_d;
    logic        commit_req_q, commit_req_d;
    logic [1:0]  commit_id_q, commit_id_d;

    logic        l_rise;
    logic        l_fall;
    logic [3:0]  hit;
    logic [1:0]  winner;
    logic [9:0]  vals [4];
    logic [9:0]  cur_val;
    logic [9:0]  track_val;
    logic        wr_en;
    logic [9:0]  wr_val;

    assign l_rise = L_BUTTON & ~l_buf_q;
    assign l_fall = ~L_BUTTON & l_buf_q;

    assign vals[HID_TRIG_LEVEL] = {1'b0, trig_level_q};
    assign vals[HID_TRIG_POS]   = trig_pos_q;
    assign vals[HID_CH1]        = {1'b0, ch1_q};
    assign vals[HID_CH2]        = {1'b0, ch2_q};
    assign cur_val              = vals[owner_q];

    drag_hit_test #(.MARK(TRIG_MARK_X)) u_hit_trig_level (
        .mark_coord_i (XCOORD),
        .track_coord_i(YCOORD),
        .value_i      (vals[HID_TRIG_LEVEL]),
        .hit_o        (hit[0])
    );

    drag_hit_test #(.MARK(TPOS_MARK_Y)) u_hit_trig_pos (
        .mark_coord_i (YCOORD),
        .track_coord_i(XCOORD),
        .value_i      (vals[HID_TRIG_POS]),
        .hit_o        (hit[1])
    );

    drag_hit_test #(.MARK(CH1_MARK_X)) u_hit_ch1 (
        .mark_coord_i (XCOORD),
        .track_coord_i(YCOORD),
        .value_i      (vals[HID_CH1]),
        .hit_o        (hit[2])
    );

    drag_hit_test #(.MARK(CH2_MARK_X)) u_hit_ch2 (
        .mark_coord_i (XCOORD),
        .track_coord_i(YCOORD),
        .value_i      (vals[HID_CH2]),
        .hit_o        (hit[3])
    );

    // Lowest handle ID wins when several windows overlap.
    always_comb begin
        if (hit[0]) begin
            winner = HID_TRIG_LEVEL;
        end else if (hit[1]) begin
            winner = HID_TRIG_POS;
        end else if (hit[2]) begin
            winner = HID_CH1;
        end else begin
            winner = HID_CH2;
        end
    end

    assign track_val = (owner_q == HID_TRIG_POS) ? clamp_coord(XCOORD, X_LO, X_HI)
                                                 : clamp_coord(YCOORD, Y_LO, Y_HI);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        saved_d      = saved_q;
        commit_req_d = commit_req_q;
        commit_id_d  = commit_id_q;
        trig_level_d = trig_level_q;
        trig_pos_d   = trig_pos_q;
        ch1_d        = ch1_q;
        ch2_d        = ch2_q;
        wr_en        = 1'b0;
        wr_val       = cur_val;

        case (state_q)
            IDLE: begin
                if (l_rise && (hit != 4'b0000)) begin
                    state_d = DRAG;
                    owner_d = winner;
                    saved_d = vals[winner];
                end
            end
            DRAG: begin
                if (R_BUTTON) begin
                    wr_en   = 1'b1;
                    wr_val  = saved_q;
                    state_d = L_BUTTON ? WAIT_REL : IDLE;
                end else if (l_fall) begin
                    if (cur_val != saved_q) begin
                        state_d      = COMMIT;
                        commit_req_d = 1'b1;
                        commit_id_d  = owner_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    wr_en  = 1'b1;
                    wr_val = track_val;
                end
            end
            COMMIT: begin
                if (COMMIT_ACK) begin
                    commit_req_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            WAIT_REL: begin
                if (!L_BUTTON) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            case (owner_q)
                HID_TRIG_LEVEL: trig_level_d = wr_val[8:0];
                HID_TRIG_POS:   trig_pos_d   = wr_val;
                HID_CH1:        ch1_d        = wr_val[8:0];
                default:        ch2_d        = wr_val[8:0];
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK_50MHZ or posedge MASTER_RST) begin
        if (MASTER_RST) begin
            state_q      <= IDLE;
            l_buf_q      <= 1'b0;
            trig_level_q <= 9'(TRIG_LEVEL_RST);
            trig_pos_q   <= 10'(TRIG_POS_RST);
            ch1_q        <= 9'(CH1_RST);
            ch2_q        <= 9'(CH2_RST);
            owner_q      <= HID_TRIG_LEVEL;
            saved_q      <= '0;
            commit_req_q <= 1'b0;
            commit_id_q  <= HID_TRIG_LEVEL;
        end else begin
            state_q      <= state_d;
            l_buf_q      <= L_BUTTON;
            trig_level_q <= trig_level_d;
            trig_pos_q   <= trig_pos_d;
            ch1_q        <= ch1_d;
            ch2_q        <= ch2_d;
            owner_q      <= owner_d;
            saved_q      <= saved_d;
            commit_req_q <= commit_req_d;
            commit_id_q  <= commit_id_d;
        end
    end

    assign TRIG_LEVEL  = trig_level_q;
    assign TRIG_POS    = trig_pos_q;
    assign CH1_OFFSET  = ch1_q;
    assign CH2_OFFSET  = ch2_q;
    assign DRAG_ACTIVE = (state_q == DRAG);
    assign DRAG_OWNER  = owner_q;
    assign COMMIT_REQ  = commit_req_q;
    assign COMMIT_ID   = commit_id_q;

endmodule

// File: tb/tb_mouse_drag_arbiter.sv
// Scoreboard bench for mouse_drag_arbiter: expectations are queued as stimulus
// is driven and compared against the DUT one clock later.
module tb_mouse_drag_arbiter;

    typedef enum int {
        S_TLVL, S_TPOS, S_CH1, S_CH2, S_ACT, S_OWN, S_REQ, S_CID,
        S_ACT2, S_OWN2, S_REQ2
    } sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        int unsigned val;
    } exp_t;

    logic        CLK_50MHZ;
    logic        MASTER_RST;
    logic [11:0] XCOORD;
    logic [11:0] YCOORD;
    logic        L_BUTTON;
    logic        R_BUTTON;
    logic        COMMIT_ACK;

    logic [8:0]  trig_level, ch1_offset, ch2_offset;
    logic [9:0]  trig_pos;
    logic        drag_active, commit_req;
    logic [1:0]  drag_owner, commit_id;

    logic [8:0]  trig_level2, ch1_offset2, ch2_offset2;
    logic [9:0]  trig_pos2;
    logic        drag_active2, commit_req2;
    logic [1:0]  drag_owner2, commit_id2;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    mouse_drag_arbiter dut (
        .CLK_50MHZ  (CLK_50MHZ),
        .MASTER_RST (MASTER_RST),
        .XCOORD     (XCOORD),
        .YCOORD     (YCOORD),
        .L_BUTTON   (L_BUTTON),
        .R_BUTTON   (R_BUTTON),
        .TRIG_LEVEL (trig_level),
        .TRIG_POS   (trig_pos),
        .CH1_OFFSET (ch1_offset),
        .CH2_OFFSET (ch2_offset),
        .DRAG_ACTIVE(drag_active),
        .DRAG_OWNER (drag_owner),
        .COMMIT_REQ (commit_req),
        .COMMIT_ID  (commit_id),
        .COMMIT_ACK (COMMIT_ACK)
    );

    // CH1 and CH2 markers stacked on the same spot to exercise priority.
    mouse_drag_arbiter #(.CH2_MARK_X(2), .CH1_RST(360)) dut_ovl (
        .CLK_50MHZ  (CLK_50MHZ),
        .MASTER_RST (MASTER_RST),
        .XCOORD     (XCOORD),
        .YCOORD     (YCOORD),
        .L_BUTTON   (L_BUTTON),
        .R_BUTTON   (R_BUTTON),
        .TRIG_LEVEL (trig_level2),
        .TRIG_POS   (trig_pos2),
        .CH1_OFFSET (ch1_offset2),
        .CH2_OFFSET (ch2_offset2),
        .DRAG_ACTIVE(drag_active2),
        .DRAG_OWNER (drag_owner2),
        .COMMIT_REQ (commit_req2),
        .COMMIT_ID  (commit_id2),
        .COMMIT_ACK (COMMIT_ACK)
    );

    initial CLK_50MHZ = 1'b0;
    always #10 CLK_50MHZ = ~CLK_50MHZ;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned observe(input sig_e s);
        case (s)
            S_TLVL: return int'(trig_level);
            S_TPOS: return int'(trig_pos);
            S_CH1:  return int'(ch1_offset);
            S_CH2:  return int'(ch2_offset);
            S_ACT:  return int'(drag_active);
            S_OWN:  return int'(drag_owner);
            S_REQ:  return int'(commit_req);
            S_CID:  return int'(commit_id);
            S_ACT2: return int'(drag_active2);
            S_OWN2: return int'(drag_owner2);
            default: return int'(commit_req2);
        endcase
    endfunction

    task automatic expect_v(input string tag, input sig_e s, input int unsigned v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    // Advance one clock, then compare everything queued for this cycle.
    task automatic step();
        @(posedge CLK_50MHZ);
        #1;
        drain();
    endtask

    task automatic drive(input logic l, input logic r, input int unsigned x, input int unsigned y);
        L_BUTTON = l;
        R_BUTTON = r;
        XCOORD   = 12'(x);
        YCOORD   = 12'(y);
    endtask

    initial begin
        MASTER_RST = 1'b1;
        COMMIT_ACK = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge CLK_50MHZ);
        #1;
        MASTER_RST = 1'b0;

        // Reset state
        expect_v("rst_tlvl", S_TLVL, 200);
        expect_v("rst_tpos", S_TPOS, 320);
        expect_v("rst_ch1",  S_CH1,  120);
        expect_v("rst_ch2",  S_CH2,  360);
        expect_v("rst_act",  S_ACT,  0);
        expect_v("rst_own",  S_OWN,  0);
        expect_v("rst_req",  S_REQ,  0);
        expect_v("rst_cid",  S_CID,  0);
        drain();

        // Grab trigger level, move, release, commit with delayed ACK
        drive(1'b1, 1'b0, 557, 200);
        expect_v("t1_act", S_ACT, 1);
        expect_v("t1_own", S_OWN, 0);
        expect_v("t1_tlvl_hold", S_TLVL, 200);
        step();
        drive(1'b1, 1'b0, 557, 250);
        expect_v("t1_tlvl_move", S_TLVL, 250);
        step();
        drive(1'b0, 1'b0, 557, 250);
        expect_v("t1_req", S_REQ, 1);
        expect_v("t1_cid", S_CID, 0);
        expect_v("t1_act_off", S_ACT, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            expect_v("t1_req_hold", S_REQ, 1);
            step();
        end
        COMMIT_ACK = 1'b1;
        expect_v("t1_req_drop", S_REQ, 0);
        expect_v("t1_tlvl_final", S_TLVL, 250);
        step();
        COMMIT_ACK = 1'b0;

        // Press just outside the trigger-level window
        drive(1'b1, 1'b0, 557, 198);
        expect_v("t2_act", S_ACT, 0);
        expect_v("t2_tlvl", S_TLVL, 250);
        expect_v("t2_tpos", S_TPOS, 320);
        expect_v("t2_ch1", S_CH1, 120);
        expect_v("t2_ch2", S_CH2, 360);
        step();
        drive(1'b0, 1'b0, 557, 198);
        step();

        // Overlapping CH1/CH2 handles: CH1 wins; release unchanged gives no commit
        drive(1'b1, 1'b0, 2, 360);
        expect_v("t3_act2", S_ACT2, 1);
        expect_v("t3_own2", S_OWN2, 2);
        expect_v("t3_act_main", S_ACT, 0);
        step();
        drive(1'b0, 1'b0, 2, 360);
        expect_v("t3_req2", S_REQ2, 0);
        expect_v("t3_act2_off", S_ACT2, 0);
        step();

        // CH2 drag with clamping at both ends
        drive(1'b1, 1'b0, 6, 360);
        expect_v("t4_own", S_OWN, 3);
        expect_v("t4_act", S_ACT, 1);
        step();
        drive(1'b1, 1'b0, 6, 600);
        expect_v("t4_clamp_hi", S_CH2, 479);
        step();
        drive(1'b1, 1'b0, 6, 0);
        expect_v("t4_clamp_lo", S_CH2, 0);
        step();
        drive(1'b0, 1'b0, 6, 0);
        expect_v("t4_req", S_REQ, 1);
        expect_v("t4_cid", S_CID, 3);
        step();
        COMMIT_ACK = 1'b1;
        expect_v("t4_req_drop", S_REQ, 0);
        step();
        COMMIT_ACK = 1'b0;
        drive(1'b1, 1'b0, 6, 2);
        expect_v("t4_miss_y2", S_ACT, 0);
        step();
        drive(1'b0, 1'b0, 6, 2);
        step();
        drive(1'b1, 1'b0, 6, 0);
        expect_v("t4_hit_at_0", S_ACT, 1);
        expect_v("t4_own_at_0", S_OWN, 3);
        step();
        drive(1'b0, 1'b0, 6, 0);
        expect_v("t4_nochg_req", S_REQ, 0);
        expect_v("t4_ch2_keep", S_CH2, 0);
        step();

        // TRIG_POS drag, cancel in the same cycle as release
        drive(1'b1, 1'b0, 320, 8);
        expect_v("t5_own", S_OWN, 1);
        step();
        drive(1'b1, 1'b0, 700, 8);
        expect_v("t5_clamp_x", S_TPOS, 639);
        step();
        drive(1'b1, 1'b0, 500, 8);
        expect_v("t5_tpos", S_TPOS, 500);
        step();
        drive(1'b0, 1'b1, 500, 8);
        expect_v("t5_restore", S_TPOS, 320);
        expect_v("t5_req", S_REQ, 0);
        expect_v("t5_act", S_ACT, 0);
        step();
        drive(1'b0, 1'b0, 500, 8);
        expect_v("t5_req_after", S_REQ, 0);
        step();

        // Cancel while still held, then re-grab only after a new press
        drive(1'b1, 1'b0, 320, 8);
        expect_v("t5b_act", S_ACT, 1);
        step();
        drive(1'b1, 1'b0, 400, 8);
        expect_v("t5b_tpos", S_TPOS, 400);
        step();
        drive(1'b1, 1'b1, 400, 8);
        expect_v("t5b_restore", S_TPOS, 320);
        expect_v("t5b_act_off", S_ACT, 0);
        step();
        drive(1'b1, 1'b0, 320, 8);
        expect_v("t5b_wait", S_ACT, 0);
        expect_v("t5b_tpos_frozen", S_TPOS, 320);
        step();
        drive(1'b0, 1'b0, 320, 8);
        step();
        drive(1'b1, 1'b0, 320, 8);
        expect_v("t5b_regrab", S_ACT, 1);
        step();
        drive(1'b0, 1'b0, 320, 8);
        step();

        // Reset while a commit is pending
        drive(1'b1, 1'b0, 557, 250);
        expect_v("t6_own", S_OWN, 0);
        step();
        drive(1'b1, 1'b0, 557, 300);
        expect_v("t6_tlvl", S_TLVL, 300);
        step();
        drive(1'b0, 1'b0, 557, 300);
        expect_v("t6_req", S_REQ, 1);
        step();
        MASTER_RST = 1'b1;
        #1;
        expect_v("t6_rst_tlvl", S_TLVL, 200);
        expect_v("t6_rst_req", S_REQ, 0);
        expect_v("t6_rst_act", S_ACT, 0);
        drain();
        @(posedge CLK_50MHZ);
        #1;
        MASTER_RST = 1'b0;
        expect_v("t6_post_req", S_REQ, 0);
        expect_v("t6_post_tlvl", S_TLVL, 200);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mouse_drag_arbiter.md
Name: mouse_drag_arbiter

Overview:
- Owns left-button drag of the four on-screen scope handles: trigger level, trigger horizontal position, CH1 offset and CH2 offset.
- On a press, hit-tests all handles and grants the drag to one owner by fixed priority. It then tracks the cursor with clamping.
- On release, it hands the final value to the acquisition config writer over a REQ/ACK handshake. A right-click cancels the drag.
- Sits between the mouse driver (coordinates and buttons) and the display and acquisition blocks.

Parameters:
- TRIG_MARK_X, 557, X centre of the trigger-level marker column.
- TPOS_MARK_Y, 8, Y centre of the trigger-position marker row.
- CH1_MARK_X, 2, X centre of the CH1 offset marker column.
- CH2_MARK_X, 6, X centre of the CH2 offset marker column.
- Y_MIN / Y_MAX, 0 / 479, clamp range for Y-driven values (9-bit).
- X_MIN / X_MAX, 0 / 639, clamp range for TRIG_POS (10-bit).
- TRIG_LEVEL_RST, TRIG_POS_RST, CH1_RST, CH2_RST: 200, 320, 120, 360 (reset values).

Ports:
- CLK_50MHZ  in  1  system clock
- MASTER_RST  in  1  asynchronous, active-high reset
- XCOORD  in  12  cursor X
- YCOORD  in  12  cursor Y
- L_BUTTON  in  1  left button level
- R_BUTTON  in  1  right button level
- TRIG_LEVEL  out  9  trigger level
- TRIG_POS  out  10  trigger horizontal position
- CH1_OFFSET  out  9  CH1 vertical offset
- CH2_OFFSET  out  9  CH2 vertical offset
- DRAG_ACTIVE  out  1  high while in DRAG
- DRAG_OWNER  out  2  handle ID being dragged (0=TRIG_LEVEL, 1=TRIG_POS, 2=CH1, 3=CH2)
- COMMIT_REQ  out  1  final value ready for the config writer
- COMMIT_ID  out  2  handle ID being committed
- COMMIT_ACK  in  1  config writer accepted the commit

Behaviour:
- Reset values:
  - Value outputs take their *_RST parameters.
  - DRAG_ACTIVE=0, DRAG_OWNER=0, COMMIT_REQ=0, COMMIT_ID=0, state IDLE.
  - Reset mid-drag or mid-commit abandons the operation; no commit is issued.
- Edge detect: Lbuf is L_BUTTON registered.
  - Lrise = L_BUTTON & ~Lbuf.
  - Lfall = ~L_BUTTON & Lbuf.
- Hit tests (combinational, all arithmetic 13-bit unsigned, so value-1 at 0 never wraps):
  - H0: X in [TRIG_MARK_X-1, +1] and Y in [TRIG_LEVEL-1, TRIG_LEVEL+1].
  - H1: Y in [TPOS_MARK_Y-1, +1] and X in [TRIG_POS-1, TRIG_POS+1].
  - H2: X in [CH1_MARK_X-1, +1] and Y in [CH1_OFFSET±1].
  - H3: X in [CH2_MARK_X-1, +1] and Y in [CH2_OFFSET±1].
  - Priority H0 > H1 > H2 > H3.
- IDLE:
  - Lrise with any hit: go to DRAG next edge. Latch the winner into DRAG_OWNER and its current value into a saved register.
  - Lrise with no hit: stay in IDLE.
- DRAG, evaluated each cycle in this order:
  1. R_BUTTON=1 (cancel wins over Lfall in the same cycle): restore the owner value from the saved register. Go to WAIT_REL, or straight to IDLE if L_BUTTON=0.
  2. Lfall: go to COMMIT if the owner value differs from the saved value, else go to IDLE.
  3. Otherwise update the owner value:
     - Y-driven handles take clamp(YCOORD, Y_MIN, Y_MAX).
     - TRIG_POS takes clamp(XCOORD, X_MIN, X_MAX).
     - Latency is 1 cycle from coordinate to output.
  - Non-owner values are frozen.
- COMMIT:
  - COMMIT_REQ=1 and COMMIT_ID=owner, registered and held until COMMIT_ACK is sampled high.
  - On that edge COMMIT_REQ drops and the state goes to IDLE.
  - Lrise and R_BUTTON are ignored. The values are stable.
- WAIT_REL: stay until L_BUTTON=0, then IDLE. This prevents re-grab within the same press.
- COMMIT_ACK outside COMMIT is ignored.
- DRAG_ACTIVE is 1 exactly while state==DRAG. DRAG_OWNER holds its last value outside DRAG.

Decomposition:
- Shared package scope_ui_pkg holds:
  - state encoding: IDLE, DRAG, COMMIT, WAIT_REL (2-bit);
  - handle ID constants HID_TRIG_LEVEL..HID_CH2;
  - the default reset values.
- One sub-module, drag_hit_test: a parameterised ±1 window compare, instantiated four times.

Test Plan:
- Reset, then press at X=557, Y=200 → DRAG_OWNER=0, DRAG_ACTIVE=1. Move Y to 250 → TRIG_LEVEL=250 one cycle later. Release → COMMIT_REQ=1, COMMIT_ID=0. ACK after 5 cycles → REQ drops, IDLE.
- Press at X=557, Y=198 (outside window) → no drag, all values unchanged.
- Overlap test: set CH1_OFFSET=360 and CH2_MARK_X=2, press at X=2, Y=360 → owner=2 (priority).
- Drag CH2 from 360, move Y=600 → CH2_OFFSET=479. Move Y=0 → CH2_OFFSET=0, with no wrap on the next hit test at value 0.
- Drag TRIG_POS to 500, then assert R_BUTTON in the same cycle as release → TRIG_POS=320, no COMMIT_REQ, IDLE.
- Drag TRIG_LEVEL to 300, assert MASTER_RST while COMMIT_REQ is high → TRIG_LEVEL=200, COMMIT_REQ=0 immediately.
